// File: rtl/hms_time_counter.sv
// BCD hours:minutes:seconds timekeeper driven by the 1 Hz enable tick.
// Set pulses take priority over ticks; rollover events are reported as one-cycle pulses.
module hms_time_counter #(
  parameter bit H24 = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       hold,
  input  logic       set_min,
  input  logic       set_hour,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [1:0] hr_tens,
  output logic       pm,
  output logic       sec_pulse,
  output logic       min_roll,
  output logic       day_wrap
);

  logic       tick;
  logic       sec_wrap;
  logic       min_wrap;
  logic       hr_last;
  logic [3:0] sec_ones_inc;
  logic [2:0] sec_tens_inc;
  logic [3:0] min_ones_inc;
  logic [2:0] min_tens_inc;
  logic [3:0] hr_ones_inc;
  logic [1:0] hr_tens_inc;
  logic       pm_inc;

  // A set pulse in the same cycle swallows the tick rather than queueing it.
  assign tick     = enable & ~hold & ~set_min & ~set_hour;
  assign sec_wrap = (sec_tens == 3'd5) && (sec_ones == 4'd9);
  assign min_wrap = (min_tens == 3'd5) && (min_ones == 4'd9);
  assign hr_last  = H24 ? ((hr_tens == 2'd2) && (hr_ones == 4'd3))
                        : ((hr_tens == 2'd1) && (hr_ones == 4'd1) && pm);

  always_comb begin
    sec_ones_inc = (sec_ones == 4'd9) ? 4'd0 : sec_ones + 4'd1;
    sec_tens_inc = sec_tens;
    if (sec_ones == 4'd9)
      sec_tens_inc = (sec_tens == 3'd5) ? 3'd0 : sec_tens + 3'd1;

    min_ones_inc = (min_ones == 4'd9) ? 4'd0 : min_ones + 4'd1;
    min_tens_inc = min_tens;
    if (min_ones == 4'd9)
      min_tens_inc = (min_tens == 3'd5) ? 3'd0 : min_tens + 3'd1;
  end

  // 12-hour sequence: 12,01..11, with pm flipping on the 11->12 step.
  always_comb begin
    hr_tens_inc = hr_tens;
    hr_ones_inc = hr_ones;
    pm_inc      = pm;
    if (H24) begin
      if ((hr_tens == 2'd2) && (hr_ones == 4'd3)) begin
        hr_tens_inc = 2'd0;
        hr_ones_inc = 4'd0;
      end else if (hr_ones == 4'd9) begin
        hr_tens_inc = hr_tens + 2'd1;
        hr_ones_inc = 4'd0;
      end else begin
        hr_ones_inc = hr_ones + 4'd1;
      end
    end else begin
      if ((hr_tens == 2'd1) && (hr_ones == 4'd1)) begin
        hr_tens_inc = 2'd1;
        hr_ones_inc = 4'd2;
        pm_inc      = ~pm;
      end else if ((hr_tens == 2'd1) && (hr_ones == 4'd2)) begin
        hr_tens_inc = 2'd0;
        hr_ones_inc = 4'd1;
      end else if (hr_ones == 4'd9) begin
        hr_tens_inc = 2'd1;
        hr_ones_inc = 4'd0;
      end else begin
        hr_ones_inc = hr_ones + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sec_ones  <= 4'd0;
      sec_tens  <= 3'd0;
      min_ones  <= 4'd0;
      min_tens  <= 3'd0;
      hr_ones   <= H24 ? 4'd0 : 4'd2;
      hr_tens   <= H24 ? 2'd0 : 2'd1;
      pm        <= 1'b0;
      sec_pulse <= 1'b0;
      min_roll  <= 1'b0;
      day_wrap  <= 1'b0;
    end else begin
      sec_pulse <= tick;
      min_roll  <= tick & sec_wrap;
      day_wrap  <= tick & sec_wrap & min_wrap & hr_last;

      if (set_min) begin
        min_ones <= min_ones_inc;
        min_tens <= min_tens_inc;
      end
      if (set_hour) begin
        hr_ones <= hr_ones_inc;
        hr_tens <= hr_tens_inc;
        pm      <= pm_inc;
      end

      if (tick) begin
        sec_ones <= sec_ones_inc;
        sec_tens <= sec_tens_inc;
        if (sec_wrap) begin
          min_ones <= min_ones_inc;
          min_tens <= min_tens_inc;
          if (min_wrap) begin
            hr_ones <= hr_ones_inc;
            hr_tens <= hr_tens_inc;
            pm      <= pm_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hms_time_counter.sv
// Bench for hms_time_counter: one 24-hour and one 12-hour instance share stimulus,
// checked against a seconds-of-day reference model plus hand-computed vectors.
module tb_hms_time_counter;

  logic clk = 1'b0;
  logic reset = 1'b0, enable = 1'b0, hold = 1'b0, set_min = 1'b0, set_hour = 1'b0;

  logic [3:0] s1_24, m1_24, h1_24, s1_12, m1_12, h1_12;
  logic [2:0] s10_24, m10_24, s10_12, m10_12;
  logic [1:0] h10_24, h10_12;
  logic       pm_24, sp_24, mr_24, dw_24, pm_12, sp_12, mr_12, dw_12;

  int nCompared = 0;
  int nMismatched = 0;
  int spCnt, mrCnt, dwCnt, coincideCnt;

  int   mh, mm, ms;
  logic msp, mmr, mdw;

  always #5 clk = ~clk;

  hms_time_counter #(.H24(1'b1)) d24 (
    .clk(clk), .reset(reset), .enable(enable), .hold(hold),
    .set_min(set_min), .set_hour(set_hour),
    .sec_ones(s1_24), .sec_tens(s10_24), .min_ones(m1_24), .min_tens(m10_24),
    .hr_ones(h1_24), .hr_tens(h10_24), .pm(pm_24),
    .sec_pulse(sp_24), .min_roll(mr_24), .day_wrap(dw_24)
  );

  hms_time_counter #(.H24(1'b0)) d12 (
    .clk(clk), .reset(reset), .enable(enable), .hold(hold),
    .set_min(set_min), .set_hour(set_hour),
    .sec_ones(s1_12), .sec_tens(s10_12), .min_ones(m1_12), .min_tens(m10_12),
    .hr_ones(h1_12), .hr_tens(h10_12), .pm(pm_12),
    .sec_pulse(sp_12), .min_roll(mr_12), .day_wrap(dw_12)
  );

  wire [23:0] a24 = {h10_24, h1_24, m10_24, m1_24, s10_24, s1_24, pm_24, sp_24, mr_24, dw_24};
  wire [23:0] a12 = {h10_12, h1_12, m10_12, m1_12, s10_12, s1_12, pm_12, sp_12, mr_12, dw_12};

  // Display image of a time of day; h is always 0..23, 12-hour view derived from it.
  function automatic logic [23:0] expVec(input bit mode12, input int h, input int m, input int s,
                                         input logic sp, input logic mr, input logic dw);
    int   hr;
    logic pmv;
    hr  = mode12 ? (((h % 12) == 0) ? 12 : (h % 12)) : h;
    pmv = mode12 && (h >= 12);
    return {2'(hr / 10), 4'(hr % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10),
            pmv, sp, mr, dw};
  endfunction

  task automatic modelStep(input logic rst, input logic en, input logic hld,
                           input logic smin, input logic shour);
    int t;
    msp = 1'b0; mmr = 1'b0; mdw = 1'b0;
    if (rst) begin
      mh = 0; mm = 0; ms = 0;
    end else if (smin || shour) begin
      if (smin)  mm = (mm + 1) % 60;
      if (shour) mh = (mh + 1) % 24;
    end else if (en && !hld) begin
      t   = mh * 3600 + mm * 60 + ms;
      msp = 1'b1;
      mmr = (ms == 59);
      mdw = (t == 86399);
      t   = (t + 1) % 86400;
      mh  = t / 3600;
      mm  = (t / 60) % 60;
      ms  = t % 60;
    end
  endtask

  task automatic cmpVec(input string name, input logic [23:0] act, input logic [23:0] req);
    nCompared++;
    if (act !== req) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int req);
    nCompared++;
    if (act != req) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic checkOutput(input string name);
    cmpVec({name, "_h24"}, a24, expVec(1'b0, mh, mm, ms, msp, mmr, mdw));
    cmpVec({name, "_h12"}, a12, expVec(1'b1, mh, mm, ms, msp, mmr, mdw));
  endtask

  task automatic checkConst(input string name, input int h, input int m, input int s,
                            input logic sp, input logic mr, input logic dw);
    cmpVec({name, "_h24"}, a24, expVec(1'b0, h, m, s, sp, mr, dw));
    cmpVec({name, "_h12"}, a12, expVec(1'b1, h, m, s, sp, mr, dw));
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic hld,
                               input logic smin, input logic shour);
    reset = rst; enable = en; hold = hld; set_min = smin; set_hour = shour;
    @(posedge clk);
    modelStep(rst, en, hld, smin, shour);
    #1;
    spCnt += int'(sp_24);
    mrCnt += int'(mr_24);
    dwCnt += int'(dw_24);
    if (sp_24 && mr_24 && dw_24) coincideCnt++;
  endtask

  task automatic clearCounts();
    spCnt = 0; mrCnt = 0; dwCnt = 0; coincideCnt = 0;
  endtask

  typedef struct {
    logic rst, en, hld, smin, shour;
    int   eh, em, es;
    logic esp, emr, edw;
  } vec_t;

  vec_t tbl[16];
  logic hv;

  initial begin
    mh = 0; mm = 0; ms = 0; msp = 1'b0; mmr = 1'b0; mdw = 1'b0;
    clearCounts();

    // Priority/collision vectors, expectations worked out by hand.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 2, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 3, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 4, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 5, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1, 5, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 5, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 5, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 5, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1, 5, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2, 2, 5, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2, 6, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0};

    // Reset held three cycles, then idle with no enable.
    clearCounts();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkConst("reset_hold", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkConst("reset_idle", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    end

    // Basic carry: 60 ticks spaced 10 cycles apart.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    clearCounts();
    for (int i = 1; i <= 60; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("carry_tick");
      if (i == 60) checkValue("carry_min_roll_after_60th", int'(mr_24), 1);
      for (int j = 0; j < 9; j++) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("carry_gap");
      end
    end
    checkConst("carry_final", 0, 1, 0, 1'b0, 1'b0, 1'b0);
    checkValue("carry_sec_pulse_count", spCnt, 60);
    checkValue("carry_min_roll_count", mrCnt, 1);

    // Day wrap: preset 23:59:58, then two more ticks.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 23; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 59; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkConst("preset_2359", 23, 59, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 58; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkConst("preset_235958", 23, 59, 58, 1'b1, 1'b0, 1'b0);
    clearCounts();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkConst("wrap_235959", 23, 59, 59, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkConst("wrap_000000", 0, 0, 0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkConst("wrap_after", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    checkValue("wrap_day_wrap_count", dwCnt, 1);
    checkValue("wrap_coincident_count", coincideCnt, 1);

    // 12-hour sequence through 24 set_hour pulses.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    clearCounts();
    for (int i = 1; i <= 24; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkConst("hour_step", i % 24, 0, 0, 1'b0, 1'b0, 1'b0);
    end
    cmpVec("hour12_back_to_12am", a12, 24'h480000);
    checkValue("hour_day_wrap_count", dwCnt, 0);

    // Reset together with enable at 00:59:59.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 59; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 59; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkConst("mid_005959", 0, 59, 59, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkConst("mid_reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Table of priority and collision vectors.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].en, tbl[i].hld, tbl[i].smin, tbl[i].shour);
      checkConst($sformatf("vec%0d", i), tbl[i].eh, tbl[i].em, tbl[i].es,
                 tbl[i].esp, tbl[i].emr, tbl[i].edw);
    end

    // Random traffic against the reference model.
    hv = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) hv = ~hv;
      applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1, hv,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
      checkOutput("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
